// File: rtl/rf_32.sv
// rf_32: 32x32 MIPS register file, two registered read ports, one write port.
// Define RF_WRITE_BYPASS_EN for write-first forwarding on same-edge collisions.
module rf_32 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  read_enabled,
    input  logic [ADDR_WIDTH-1:0] read_addr_s,
    input  logic [ADDR_WIDTH-1:0] read_addr_t,
    input  logic                  write_enabled,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] outA,
    output logic [DATA_WIDTH-1:0] outB
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] register_file [0:DEPTH-1];
    logic                  wr_hit;
    logic [DATA_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_b;

    // Writes to r0 never land, so r0 keeps its reset value of zero.
    assign wr_hit = write_enabled && (write_addr != '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                register_file[i] <= '0;
            end
        end else if (wr_hit) begin
            register_file[write_addr] <= write_data;
        end
    end

    always_comb begin
        rd_a = register_file[read_addr_s];
        rd_b = register_file[read_addr_t];
`ifdef RF_WRITE_BYPASS_EN
        if (wr_hit && (write_addr == read_addr_s)) begin
            rd_a = write_data;
        end
        if (wr_hit && (write_addr == read_addr_t)) begin
            rd_b = write_data;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            outA <= '0;
            outB <= '0;
        end else if (read_enabled) begin
            outA <= rd_a;
            outB <= rd_b;
        end
    end

endmodule

// File: tb/tb_rf_32.sv
// tb_rf_32: directed self-checking bench for rf_32.
// Collision expectations follow RF_WRITE_BYPASS_EN.
module tb_rf_32;

    logic        clock;
    logic        reset_n;
    logic        read_enabled;
    logic [4:0]  read_addr_s;
    logic [4:0]  read_addr_t;
    logic        write_enabled;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [31:0] outA;
    logic [31:0] outB;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] fill [0:31];

    rf_32 dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .read_enabled  (read_enabled),
        .read_addr_s   (read_addr_s),
        .read_addr_t   (read_addr_t),
        .write_enabled (write_enabled),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .outA          (outA),
        .outB          (outB)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        read_enabled  = 1'b0;
        write_enabled = 1'b0;
        read_addr_s   = '0;
        read_addr_t   = '0;
        write_addr    = '0;
        write_data    = '0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        read_enabled  = 1'b0;
        write_enabled = 1'b1;
        write_addr    = a;
        write_data    = d;
        tick();
        write_enabled = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        #12;
        reset_n = 1'b1;
        read_enabled = 1'b1;
        for (int a = 0; a < 32; a++) begin
            read_addr_s = 5'(a);
            read_addr_t = 5'(31 - a);
            tick();
            vectors++;
            if (outA !== 32'h0 || outB !== 32'h0) begin
                errors++;
                $display("FAIL reset_read a=%0d outA=%h outB=%h want 0", a, outA, outB);
            end
        end
        do_write(5'd3, 32'hAAAA5555);
        read_enabled = 1'b1;
        read_addr_s  = 5'd3;
        read_addr_t  = 5'd3;
        tick();
        vectors++;
        if (outA !== 32'hAAAA5555 || outB !== 32'hAAAA5555) begin
            errors++;
            $display("FAIL pre_reset_read outA=%h outB=%h want aaaa5555", outA, outB);
        end
        #3;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (outA !== 32'h0 || outB !== 32'h0 || dut.register_file[3] !== 32'h0) begin
            errors++;
            $display("FAIL async_reset outA=%h outB=%h r3=%h want 0",
                     outA, outB, dut.register_file[3]);
        end
        write_enabled = 1'b1;
        write_addr    = 5'd9;
        write_data    = 32'hCAFEF00D;
        tick();
        tick();
        write_enabled = 1'b0;
        #2;
        reset_n = 1'b1;
        vectors++;
        if (dut.register_file[9] !== 32'h0 || outA !== 32'h0) begin
            errors++;
            $display("FAIL write_in_reset r9=%h outA=%h want 0", dut.register_file[9], outA);
        end
        idle();
    endtask

    task automatic test_zero_reg();
        read_enabled  = 1'b1;
        write_enabled = 1'b1;
        write_addr    = 5'd0;
        write_data    = 32'hDEADBEEF;
        read_addr_s   = 5'd0;
        read_addr_t   = 5'd0;
        tick();
        vectors++;
        if (outA !== 32'h0 || outB !== 32'h0 || dut.register_file[0] !== 32'h0) begin
            errors++;
            $display("FAIL zero_reg outA=%h outB=%h r0=%h want 0",
                     outA, outB, dut.register_file[0]);
        end
        idle();
    endtask

    task automatic test_fill_readback();
        fill[0] = 32'h0;
        for (int a = 1; a <= 16; a++) fill[a] = 32'(a - 1) * 32'h11111111;
        for (int a = 17; a <= 30; a++) fill[a] = 32'(a - 16);
        fill[31] = 32'hDEADBEEF;
        for (int a = 1; a < 32; a++) do_write(5'(a), fill[a]);
        read_enabled = 1'b1;
        for (int a = 0; a < 32; a++) begin
            read_addr_s = 5'(a);
            tick();
            vectors++;
            if (outA !== fill[a]) begin
                errors++;
                $display("FAIL rs_sweep a=%0d outA=%h want %h", a, outA, fill[a]);
            end
        end
        for (int a = 0; a < 32; a++) begin
            read_addr_t = 5'(a);
            tick();
            vectors++;
            if (outB !== fill[a]) begin
                errors++;
                $display("FAIL rt_sweep a=%0d outB=%h want %h", a, outB, fill[a]);
            end
        end
        idle();
    endtask

    task automatic test_hold();
        do_write(5'd5, 32'h44444444);
        read_enabled = 1'b1;
        read_addr_s  = 5'd5;
        tick();
        vectors++;
        if (outA !== 32'h44444444) begin
            errors++;
            $display("FAIL hold_load outA=%h want 44444444", outA);
        end
        read_enabled = 1'b0;
        read_addr_s  = 5'd6;
        tick();
        tick();
        vectors++;
        if (outA !== 32'h44444444) begin
            errors++;
            $display("FAIL hold outA=%h want 44444444", outA);
        end
        idle();
    endtask

    task automatic test_collision();
        logic [31:0] exp;
`ifdef RF_WRITE_BYPASS_EN
        exp = 32'h12345678;
`else
        exp = 32'h66666666;
`endif
        do_write(5'd7, 32'h66666666);
        read_enabled  = 1'b1;
        write_enabled = 1'b1;
        write_addr    = 5'd7;
        write_data    = 32'h12345678;
        read_addr_s   = 5'd7;
        read_addr_t   = 5'd7;
        tick();
        write_enabled = 1'b0;
        vectors++;
        if (outA !== exp || outB !== exp) begin
            errors++;
            $display("FAIL collision outA=%h outB=%h want %h", outA, outB, exp);
        end
        tick();
        vectors++;
        if (outA !== 32'h12345678 || outB !== 32'h12345678) begin
            errors++;
            $display("FAIL after_collision outA=%h outB=%h want 12345678", outA, outB);
        end
        idle();
    endtask

    task automatic test_dual_port();
        read_enabled = 1'b1;
        read_addr_s  = 5'd31;
        read_addr_t  = 5'd16;
        tick();
        vectors++;
        if (outA !== 32'hDEADBEEF || outB !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL dual_port outA=%h outB=%h want deadbeef ffffffff", outA, outB);
        end
        idle();
    endtask

    initial begin
        reset_n = 1'b1;
        idle();
        @(negedge clock);
        test_reset();
        test_zero_reg();
        test_fill_readback();
        test_hold();
        test_collision();
        test_dual_port();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
